modport_fifo: RTL and testbench
===============================

MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of storage entries; legal range is 4 or more.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port data_in, input, FIFO_WIDTH bits; write data.
REQ-006 SHALL have port wr_en, input, 1 bit; write request.
REQ-007 SHALL have port rd_en, input, 1 bit; read request.
REQ-008 SHALL have port data_out, output, FIFO_WIDTH bits; registered read data.
REQ-009 SHALL have port wr_ack, output, 1 bit; registered, accepted-write acknowledge.
REQ-010 SHALL have port overflow, output, 1 bit; registered, rejected-write flag.
REQ-011 SHALL have port underflow, output, 1 bit; registered, rejected-read flag.
REQ-012 SHALL have ports full, almostfull, empty and almostempty, each an output of 1 bit; combinational occupancy flags.

Function
REQ-013 SHALL store words in a circular buffer with write and read pointers that wrap from FIFO_DEPTH-1 to 0, and an occupancy count of clog2(FIFO_DEPTH)+1 bits.
REQ-014 SHALL accept a write on a rising clk edge when wr_en=1 and the FIFO is not full, as follows:
- store data_in at the write pointer;
- advance the write pointer;
- set wr_ack=1 for that cycle.
REQ-015 SHALL set overflow=1 and wr_ack=0 on a rising clk edge when wr_en=1 and full=1, leaving storage unchanged.
REQ-016 SHALL clear wr_ack and overflow at each rising clk edge when wr_en=0.
REQ-017 SHALL accept a read on a rising clk edge when rd_en=1 and the FIFO is not empty, as follows:
- load data_out with the entry at the read pointer (latency one clock);
- advance the read pointer.
REQ-018 SHALL hold data_out unchanged in every cycle with no accepted read.
REQ-019 SHALL set underflow=1 on a rising clk edge when rd_en=1 and empty=1, and clear it otherwise; a rejected read SHALL leave data_out and the pointers unchanged.
REQ-020 SHALL perform both operations in the same cycle when wr_en=1, rd_en=1, and the FIFO is neither full nor empty, keeping count unchanged.
REQ-021 SHALL, when wr_en=1 and rd_en=1 with the FIFO full, perform the read only: count decrements, overflow=1, wr_ack=0.
REQ-022 SHALL, when wr_en=1 and rd_en=1 with the FIFO empty, perform the write only: count increments, wr_ack=1, underflow=1.
REQ-023 SHALL drive full=1 exactly when count==FIFO_DEPTH, and empty=1 exactly when count==0.
REQ-024 SHALL drive almostfull=1 exactly when count==FIFO_DEPTH-1, and almostempty=1 exactly when count==1.
REQ-025 SHALL return words in exact write order across any number of pointer wraps.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, clear the following:
- the pointers and count;
- data_out;
- wr_ack, overflow and underflow.
REQ-027 SHALL therefore show empty=1, full=0, almostfull=0 and almostempty=0 during reset; storage contents need not be cleared.
REQ-028 SHALL discard all contents on reset asserted mid-operation, and resume normal operation at the first rising clk edge after rst_n=1.

Configuration
REQ-029 SHALL compile in embedded protocol assertions only when macro FIFO_SVA_EN is defined; the assertions SHALL check:
- count never exceeds FIFO_DEPTH;
- full and empty are never both 1;
- wr_ack and overflow are never both 1;
- each flag matches its count definition;
- every output is 0 (empty is 1) one cycle after reset.
REQ-030 SHALL, without FIFO_SVA_EN, contain no assertion code; port behaviour SHALL be identical in both builds.

Verification
REQ-031 SHALL be covered by a reset test: assert rst_n=0 mid-stream after three writes -> empty=1, data_out=0, wr_ack/overflow/underflow=0 without waiting for a clk edge.
REQ-032 SHALL be covered by a fill/overflow test: with FIFO_DEPTH=8, write 0x0001..0x0008 -> almostfull=1 after 7 writes and full=1 after 8; a 9th write of 0x0009 -> overflow=1, wr_ack=0, contents unchanged.
REQ-033 SHALL be covered by a drain/underflow test: read 8 times -> data_out=0x0001..0x0008 in order, each one clock after its read; almostempty=1 at count 1; a 9th read -> underflow=1, data_out holds 0x0008.
REQ-034 SHALL be covered by a simultaneous test at count 4: wr_en=rd_en=1 with data_in=0xABCD -> count stays 4, wr_ack=1, oldest word appears on data_out.
REQ-035 SHALL be covered by boundary simultaneous tests:
- wr_en=rd_en=1 when full -> read only, overflow=1;
- wr_en=rd_en=1 when empty with data_in=0x1234 -> write only, underflow=1, then a later read returns 0x1234.
REQ-036 SHALL be covered by a wrap test: 20 interleaved write/read pairs of random data -> output sequence identical to the input sequence.

Source files
------------

// File: rtl/modport_fifo.sv
// modport_fifo: circular-buffer FIFO with registered data/ack/error outputs and combinational occupancy flags.
// Define FIFO_SVA_EN to compile in the embedded protocol assertions.
module modport_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  do_wr, do_rd;

    assign full        = count_q == CW'(FIFO_DEPTH);
    assign almostfull  = count_q == CW'(FIFO_DEPTH - 1);
    assign empty       = count_q == '0;
    assign almostempty = count_q == CW'(1);

    always_comb begin
        do_wr       = wr_en && !full;
        do_rd       = rd_en && !empty;
        wr_ptr_d    = do_wr ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d    = do_rd ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d     = (do_wr && !do_rd) ? count_q + CW'(1) :
                      (do_rd && !do_wr) ? count_q - CW'(1) : count_q;
        data_out_d  = do_rd ? mem_q[rd_ptr_q] : data_out_q;
        wr_ack_d    = do_wr;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;
    end

    // Storage is deliberately left out of reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FIFO_SVA_EN
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(FIFO_DEPTH));
    a_full_empty: assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
    a_ack_ovf: assert property (@(posedge clk) disable iff (!rst_n) !(wr_ack && overflow));
    a_flags: assert property (@(posedge clk) disable iff (!rst_n)
        full == (count_q == CW'(FIFO_DEPTH)) && almostfull == (count_q == CW'(FIFO_DEPTH - 1)) &&
        empty == (count_q == '0) && almostempty == (count_q == CW'(1)));
    a_reset: assert property (@(posedge clk) !rst_n |=>
        data_out == '0 && !wr_ack && !overflow && !underflow && !full && !almostfull && empty && !almostempty);
`else
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: randomized and directed checks of modport_fifo against a queue-based reference model.
module tb_modport_fifo;
    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow, full, almostfull, empty, almostempty;

    modport_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout = '0;
    logic         exp_ack = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
    logic [W-1:0] wrap_in[$];
    logic [W-1:0] wrap_out[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        check({tag, ".wr_ack"}, 32'(wr_ack), 32'(exp_ack));
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
        check({tag, ".full"}, 32'(full), 32'(n == D));
        check({tag, ".almostfull"}, 32'(almostfull), 32'(n == D - 1));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".almostempty"}, 32'(almostempty), 32'(n == 1));
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ack = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic step(input string tag, input logic w, input logic r, input logic [W-1:0] d);
        int n;
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(posedge clk);
        n = q.size();
        exp_ack = w && n < D;
        exp_ovf = w && n == D;
        exp_unf = r && n == 0;
        if (r && n > 0) exp_dout = q.pop_front();
        if (w && n < D) q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #1;
        check_all("reset_initial");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("idle", 1'b0, 1'b0, '0);

        step("pre_rst_w", 1'b1, 1'b0, 16'h00A1);
        step("pre_rst_w", 1'b1, 1'b0, 16'h00A2);
        step("pre_rst_w", 1'b1, 1'b0, 16'h00A3);
        step("pre_rst_r", 1'b0, 1'b1, '0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("reset_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, '0);

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, W'(i));
        step("overflow", 1'b1, 1'b0, 16'h0009);
        for (int i = 1; i <= 8; i++) step("drain", 1'b0, 1'b1, '0);
        check("drain_last", 32'(data_out), 32'h0008);
        step("underflow", 1'b0, 1'b1, '0);
        check("underflow_hold", 32'(data_out), 32'h0008);

        for (int i = 0; i < 4; i++) step("to4", 1'b1, 1'b0, W'(16'h0100 + i));
        step("simul4", 1'b1, 1'b1, 16'hABCD);
        check("simul4_oldest", 32'(data_out), 32'h0100);
        for (int i = 0; i < 4; i++) step("to_full", 1'b1, 1'b0, W'(16'h0200 + i));
        step("simul_full", 1'b1, 1'b1, 16'hDEAD);
        while (q.size() > 0) step("to_empty", 1'b0, 1'b1, '0);
        step("simul_empty", 1'b1, 1'b1, 16'h1234);
        step("read_1234", 1'b0, 1'b1, '0);
        check("simul_empty_data", 32'(data_out), 32'h1234);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            wrap_in.push_back(v);
            step("wrap_w", 1'b1, 1'b0, v);
            step("wrap_r", 1'b0, 1'b1, '0);
            wrap_out.push_back(data_out);
        end
        for (int i = 0; i < 20; i++) check("wrap_order", 32'(wrap_out[i]), 32'(wrap_in[i]));

        for (int i = 0; i < 400; i++)
            step("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), W'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
